// File: rtl/bcd_counter_display_if.sv
// Control and display bundle for bcd_counter_display.
//   en, up, clear : count controls driven by the board/host (master)
//   seg           : active-low segments, seg[0]=a .. seg[6]=g
//   anode_sel     : active-low one-hot digit select
//   led           : terminal-count indicator
//   count_bcd     : live BCD count, nibble k = digit k
interface bcd_counter_display_if #(
  parameter int DIGITS = 4
);
  logic                  en;
  logic                  up;
  logic                  clear;
  logic [6:0]            seg;
  logic [DIGITS-1:0]     anode_sel;
  logic                  led;
  logic [4*DIGITS-1:0]   count_bcd;

  modport master (output en, up, clear, input seg, anode_sel, led, count_bcd);
  modport slave  (input en, up, clear, output seg, anode_sel, led, count_bcd);
endinterface

// File: rtl/bcd_counter_display.sv
// Multi-digit BCD up/down event counter with a time-multiplexed
// seven-segment driver and optional leading-zero blanking.
//   clk_fpga : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : slave side of bcd_counter_display_if (en/up/clear in,
//              seg/anode_sel/led/count_bcd out)
module bcd_counter_display #(
  parameter int                  CLK_HZ     = 100_000_000,
  parameter int                  TICK_HZ    = 1,
  parameter int                  REFRESH_HZ = 1000,
  parameter int                  DIGITS     = 4,
  parameter logic [4*DIGITS-1:0] TOP_BCD    = {DIGITS{4'h9}},
  parameter bit                  BLANK_LZ   = 1'b1
) (
  input  logic                  clk_fpga,
  input  logic                  reset_n,
  bcd_counter_display_if.slave  bus
);
  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int SCAN_DIV = CLK_HZ / (REFRESH_HZ * DIGITS);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1)   ? $clog2(DIGITS)   : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  // ---------------- tick divider (free-running, ignores en) ----------------
  logic [TW-1:0] tick_cnt;
  logic          tick;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk_fpga or negedge reset_n) begin
    if (!reset_n)  tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  // ---------------- BCD counter ----------------
  logic [DIGITS-1:0][3:0] cnt, cnt_inc, cnt_dec;
  logic                   at_top, at_zero, carry, borrow;

  assign at_top  = (cnt == TOP_BCD);
  assign at_zero = (cnt == '0);

  // Full ripple in one cycle: a digit only moves while the carry/borrow
  // from below is still live.
  always_comb begin
    cnt_inc = cnt;
    cnt_dec = cnt;
    carry   = 1'b1;
    borrow  = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (carry) begin
        if (cnt[k] >= 4'd9) cnt_inc[k] = 4'd0;
        else begin
          cnt_inc[k] = cnt[k] + 4'd1;
          carry      = 1'b0;
        end
      end
      if (borrow) begin
        if (cnt[k] == 4'd0) cnt_dec[k] = 4'd9;
        else begin
          cnt_dec[k] = cnt[k] - 4'd1;
          borrow     = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_fpga or negedge reset_n) begin
    if (!reset_n)                cnt <= '0;
    else if (bus.clear)          cnt <= '0;
    else if (tick && bus.en) begin
      if (bus.up) cnt <= at_top  ? '0      : cnt_inc;
      else        cnt <= at_zero ? TOP_BCD : cnt_dec;
    end
  end

  assign bus.count_bcd = cnt;
  assign bus.led       = bus.up ? at_top : at_zero;

  // ---------------- scan divider / digit index ----------------
  logic [SW-1:0] scan_cnt;
  logic [IW-1:0] idx;

  always_ff @(posedge clk_fpga or negedge reset_n) begin
    if (!reset_n) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // ---------------- blanking ----------------
  // zero_run tracks "this digit and everything above it is 0", scanning
  // from the most significant digit down. Digit 0 is never blanked.
  logic [DIGITS-1:0] blank;
  logic              zero_run;

  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run & (cnt[k] == 4'd0);
      blank[k] = BLANK_LZ && (k != 0) && zero_run;
    end
  end

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'b1000000;
      4'd1:    seg_of = 7'b1111001;
      4'd2:    seg_of = 7'b0100100;
      4'd3:    seg_of = 7'b0110000;
      4'd4:    seg_of = 7'b0011001;
      4'd5:    seg_of = 7'b0010010;
      4'd6:    seg_of = 7'b0000010;
      4'd7:    seg_of = 7'b1111000;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0010000;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  // Anode and segments come from the same idx in the same register stage,
  // so they can never disagree about which digit is shown.
  logic [6:0]        seg_r;
  logic [DIGITS-1:0] an_r;

  always_ff @(posedge clk_fpga or negedge reset_n) begin
    if (!reset_n) begin
      seg_r <= 7'b1000000;
      an_r  <= ~DIGITS'(1);
    end else begin
      seg_r <= blank[idx] ? 7'b1111111 : seg_of(cnt[idx]);
      an_r  <= ~(DIGITS'(1) << idx);
    end
  end

  assign bus.seg       = seg_r;
  assign bus.anode_sel = an_r;
endmodule

// File: tb/tb_bcd_counter_display.sv
// Directed bench for bcd_counter_display. Three instances share clock and
// reset: a = default TOP/blanking, b = TOP 0012, c = BLANK_LZ=0 mirroring a.
module tb_bcd_counter_display;
  logic clk = 1'b0;
  logic reset_n;
  int   n_chk = 0;
  int   n_fail = 0;
  int   ecnt = 0;   // rising edges since last reset release

  always #5 clk = ~clk;

  bcd_counter_display_if #(.DIGITS(4)) a_if ();
  bcd_counter_display_if #(.DIGITS(4)) b_if ();
  bcd_counter_display_if #(.DIGITS(4)) c_if ();

  assign c_if.en    = a_if.en;
  assign c_if.up    = a_if.up;
  assign c_if.clear = a_if.clear;

  bcd_counter_display #(.CLK_HZ(100), .TICK_HZ(10), .REFRESH_HZ(5), .DIGITS(4))
    dut_a (.clk_fpga(clk), .reset_n(reset_n), .bus(a_if));
  bcd_counter_display #(.CLK_HZ(100), .TICK_HZ(10), .REFRESH_HZ(5), .DIGITS(4),
                        .TOP_BCD(16'h0012))
    dut_b (.clk_fpga(clk), .reset_n(reset_n), .bus(b_if));
  bcd_counter_display #(.CLK_HZ(100), .TICK_HZ(10), .REFRESH_HZ(5), .DIGITS(4),
                        .BLANK_LZ(1'b0))
    dut_c (.clk_fpga(clk), .reset_n(reset_n), .bus(c_if));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, ecnt, act, exp);
    end
  endtask

  // Advance one rising edge per iteration; return parked on the falling edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      ecnt++;
      @(negedge clk);
    end
  endtask

  task automatic go_to(input int t);
    if (t > ecnt) step(t - ecnt);
  endtask

  logic [6:0] seg_a [4] = '{7'b0100100, 7'b0011001, 7'b1111111, 7'b1111111};
  logic [6:0] seg_c [4] = '{7'b0100100, 7'b0011001, 7'b1000000, 7'b1000000};
  logic [3:0] an_e;
  int         di;

  initial begin
    reset_n    = 1'b0;
    a_if.en    = 1'b0; a_if.up = 1'b1; a_if.clear = 1'b0;
    b_if.en    = 1'b0; b_if.up = 1'b0; b_if.clear = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // reset state
    chk("rst_count", a_if.count_bcd, 16'h0000);
    chk("rst_anode", a_if.anode_sel, 4'b1110);
    chk("rst_seg",   a_if.seg,       7'b1000000);
    chk("rst_led_up", a_if.led,      1'b0);
    chk("rst_led_dn", b_if.led,      1'b1);

    // release, count up
    b_if.up = 1'b1;
    a_if.en = 1'b1;
    b_if.en = 1'b1;
    reset_n = 1'b1;
    ecnt    = 0;

    go_to(9);   chk("first_tick_pre", a_if.count_bcd, 16'h0000);
    go_to(10);  chk("first_tick",     a_if.count_bcd, 16'h0001);
    go_to(20);  chk("second_tick",    a_if.count_bcd, 16'h0002);

    // b: terminal count 0012, wrap, then count down
    go_to(120); chk("b_top",      b_if.count_bcd, 16'h0012);
                chk("b_led_top",  b_if.led,       1'b1);
    go_to(129); chk("b_top_hold", b_if.count_bcd, 16'h0012);
                chk("b_led_hold", b_if.led,       1'b1);
    go_to(130); chk("b_wrap",     b_if.count_bcd, 16'h0000);
                chk("b_led_wrap", b_if.led,       1'b0);
    b_if.up = 1'b0;
    #1;         chk("b_led_dn0",  b_if.led,       1'b1);
    go_to(140); chk("b_dn_wrap",  b_if.count_bcd, 16'h0012);
                chk("b_led_dn12", b_if.led,       1'b0);
    go_to(170); chk("b_borrow",   b_if.count_bcd, 16'h0009);
                chk("a_at170",    a_if.count_bcd, 16'h0017);
    b_if.en = 1'b0;

    // freeze a at 0042 and watch a full scan
    go_to(420); chk("a_42", a_if.count_bcd, 16'h0042);
    a_if.en = 1'b0;
    for (int e = 421; e <= 440; e++) begin
      go_to(e);
      di   = ((e - 1) / 5) % 4;
      an_e = ~(4'b0001 << di);
      chk("scan_an",   a_if.anode_sel, an_e);
      chk("scan_seg",  a_if.seg,       seg_a[di]);
      chk("scan_an_c", c_if.anode_sel, an_e);
      chk("scan_seg_c", c_if.seg,      seg_c[di]);
    end

    // resume up to 0099 -> 0100
    a_if.en = 1'b1;
    go_to(1019); chk("a_99",      a_if.count_bcd, 16'h0099);
    go_to(1020); chk("a_100",     a_if.count_bcd, 16'h0100);
                 chk("a_led_100", a_if.led,       1'b0);

    // clear on a tick edge wins over increment
    go_to(1029);
    a_if.clear = 1'b1;
    go_to(1030); chk("clr_on_tick", a_if.count_bcd, 16'h0000);
    a_if.clear = 1'b0;
    go_to(1060); chk("a_3", a_if.count_bcd, 16'h0003);
    a_if.en = 1'b0;
    go_to(1090); chk("en_off_hold", a_if.count_bcd, 16'h0003);

    // clear without a tick
    a_if.clear = 1'b1;
    go_to(1091); chk("clr_no_tick", a_if.count_bcd, 16'h0000);
    a_if.clear = 1'b0;

    // count down from 0 wraps to TOP
    a_if.up = 1'b0;
    #1;          chk("a_led_dn0", a_if.led, 1'b1);
    a_if.en = 1'b1;
    go_to(1100); chk("dn_wrap",   a_if.count_bcd, 16'h9999);
                 chk("a_led_dn",  a_if.led,       1'b0);
    go_to(1110); chk("dn_borrow", a_if.count_bcd, 16'h9998);

    // clear, count up to 0357, async reset mid-scan
    a_if.up    = 1'b1;
    a_if.clear = 1'b1;
    go_to(1111); chk("clr2", a_if.count_bcd, 16'h0000);
    a_if.clear = 1'b0;
    go_to(4682); chk("a_357", a_if.count_bcd, 16'h0357);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_count", a_if.count_bcd, 16'h0000);
    chk("arst_anode", a_if.anode_sel, 4'b1110);
    chk("arst_seg",   a_if.seg,       7'b1000000);
    chk("arst_led",   a_if.led,       1'b0);
    chk("arst_led_b", b_if.led,       1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    ecnt    = 0;
    go_to(9);  chk("rel_pre",   a_if.count_bcd, 16'h0000);
    go_to(10); chk("rel_tick",  a_if.count_bcd, 16'h0001);
               chk("rel_anode", a_if.anode_sel, 4'b1101);
               chk("rel_seg",   a_if.seg,       7'b1111111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
